// File: rtl/snn_ctrl_pkg.sv
// Shared definitions for the integrate-and-fire network sample scheduler.
//   ctrl_state_t : controller FSM states
//   clog2_min1   : ceil(log2(x)) clamped to at least 1 bit, used for
//                  counter and index widths so degenerate sizes stay legal.
package snn_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_RUN,
        ST_DRAIN,
        ST_SCAN,
        ST_RESULT
    } ctrl_state_t;

    function automatic int clog2_min1(input int value);
        return (value > 1) ? $clog2(value) : 1;
    endfunction

endpackage

// File: rtl/spike_counter_bank.sv
// Bank of saturating per-neuron spike counters with an indexed read port.
//   clk, rst   : clock, synchronous active-high reset
//   i_clr      : zero all counters (start of a sample)
//   i_en       : counting window enable
//   i_spike    : one spike bit per output neuron
//   i_rd_idx   : neuron selected for the scan read
//   o_rd_data  : count of the selected neuron (0 if index out of range)
module spike_counter_bank #(
    parameter int NUM_OUTPUTS = 4,
    parameter int CNT_W       = 5,
    parameter int IDX_W       = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_clr,
    input  logic                   i_en,
    input  logic [NUM_OUTPUTS-1:0] i_spike,
    input  logic [IDX_W-1:0]       i_rd_idx,
    output logic [CNT_W-1:0]       o_rd_data
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [NUM_OUTPUTS-1:0][CNT_W-1:0] w_cnt;

    generate
        for (genvar gi = 0; gi < NUM_OUTPUTS; gi++) begin : g_cnt
            logic [CNT_W-1:0] r_cnt;

            // Saturate instead of wrapping so a busy neuron can never
            // appear to have fewer spikes than a quieter one.
            always_ff @(posedge clk) begin
                if (rst || i_clr) begin
                    r_cnt <= '0;
                end else if (i_en && i_spike[gi] && (r_cnt != CNT_MAX)) begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end

            assign w_cnt[gi] = r_cnt;
        end
    endgenerate

    always_comb begin
        o_rd_data = '0;
        for (int k = 0; k < NUM_OUTPUTS; k++) begin
            if (i_rd_idx == IDX_W'(k)) begin
                o_rd_data = w_cnt[k];
            end
        end
    end

endmodule

// File: rtl/if_network_controller.sv
// Sample-level scheduler for the integrate-and-fire network: clears the
// network, streams NUM_TIMESTEPS spike vectors into it, drains in-flight
// spikes, counts output spikes per neuron and reports the argmax.
//   clk, rst                      : clock, synchronous active-high reset
//   in_valid/in_ready/in_spikes   : upstream timestep stream
//   net_spike_in, net_rst         : drive the network
//   net_spike_out                 : network output-layer spikes
//   out_valid/out_ready           : result handshake
//   out_winner/out_count/out_silent : winning neuron, its count, all-zero flag
//   busy                          : controller not idle
module if_network_controller
    import snn_ctrl_pkg::*;
#(
    parameter int NUM_INPUTS    = 4,
    parameter int NUM_OUTPUTS   = 4,
    parameter int NUM_TIMESTEPS = 16,
    parameter int CLEAR_CYCLES  = 2,
    parameter int DRAIN_CYCLES  = 2,
    parameter int CNT_W         = clog2_min1(NUM_TIMESTEPS + DRAIN_CYCLES + 1),
    parameter int IDX_W         = clog2_min1(NUM_OUTPUTS)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [NUM_INPUTS-1:0]  in_spikes,
    output logic [NUM_INPUTS-1:0]  net_spike_in,
    output logic                   net_rst,
    input  logic [NUM_OUTPUTS-1:0] net_spike_out,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [IDX_W-1:0]       out_winner,
    output logic [CNT_W-1:0]       out_count,
    output logic                   out_silent,
    output logic                   busy
);

    localparam int TS_W   = clog2_min1(NUM_TIMESTEPS + 1);
    localparam int PH_MAX = (CLEAR_CYCLES > DRAIN_CYCLES) ? CLEAR_CYCLES : DRAIN_CYCLES;
    localparam int PH_W   = clog2_min1(PH_MAX + 1);

    ctrl_state_t           r_state;
    ctrl_state_t           w_state_next;
    logic [PH_W-1:0]       r_phase;
    logic [TS_W-1:0]       r_ts_cnt;
    logic [IDX_W-1:0]      r_scan_idx;
    logic [IDX_W-1:0]      r_winner;
    logic [CNT_W-1:0]      r_best;
    logic [NUM_INPUTS-1:0] r_net_spike_in;
    logic                  w_in_ready;
    logic                  w_hs;
    logic                  w_cnt_clr;
    logic                  w_cnt_en;
    logic [CNT_W-1:0]      w_rd_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_in_ready   = 1'b0;
        w_cnt_clr    = 1'b0;
        w_cnt_en     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                // The triggering beat is left in place; it is taken in RUN.
                if (in_valid) begin
                    w_state_next = ST_CLEAR;
                    w_cnt_clr    = 1'b1;
                end
            end
            ST_CLEAR: begin
                if (r_phase == PH_W'(CLEAR_CYCLES - 1)) begin
                    w_state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                w_in_ready = 1'b1;
                w_cnt_en   = 1'b1;
                if (in_valid && (r_ts_cnt == TS_W'(NUM_TIMESTEPS - 1))) begin
                    w_state_next = (DRAIN_CYCLES == 0) ? ST_SCAN : ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                w_cnt_en = 1'b1;
                if (r_phase == PH_W'(DRAIN_CYCLES - 1)) begin
                    w_state_next = ST_SCAN;
                end
            end
            ST_SCAN: begin
                if (r_scan_idx == IDX_W'(NUM_OUTPUTS - 1)) begin
                    w_state_next = ST_RESULT;
                end
            end
            ST_RESULT: begin
                if (out_ready) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    assign w_hs = w_in_ready & in_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_phase        <= '0;
            r_ts_cnt       <= '0;
            r_scan_idx     <= '0;
            r_winner       <= '0;
            r_best         <= '0;
            r_net_spike_in <= '0;
        end else begin
            // Phase counter restarts on every state change and only
            // advances in the fixed-length states it times.
            if (w_state_next != r_state) begin
                r_phase <= '0;
            end else if ((r_state == ST_CLEAR) || (r_state == ST_DRAIN)) begin
                r_phase <= r_phase + 1'b1;
            end

            if (w_cnt_clr) begin
                r_ts_cnt <= '0;
            end else if (w_hs) begin
                r_ts_cnt <= r_ts_cnt + 1'b1;
            end

            // Each accepted vector is presented to the network for one cycle.
            r_net_spike_in <= w_hs ? in_spikes : '0;

            // Index 0 seeds the running max; later neurons replace it only
            // when strictly larger, so ties keep the lowest index.
            if (r_state == ST_SCAN) begin
                r_scan_idx <= r_scan_idx + 1'b1;
                if ((r_scan_idx == '0) || (w_rd_count > r_best)) begin
                    r_winner <= r_scan_idx;
                    r_best   <= w_rd_count;
                end
            end else begin
                r_scan_idx <= '0;
            end
        end
    end

    spike_counter_bank #(
        .NUM_OUTPUTS (NUM_OUTPUTS),
        .CNT_W       (CNT_W),
        .IDX_W       (IDX_W)
    ) u_counters (
        .clk       (clk),
        .rst       (rst),
        .i_clr     (w_cnt_clr),
        .i_en      (w_cnt_en),
        .i_spike   (net_spike_out),
        .i_rd_idx  (r_scan_idx),
        .o_rd_data (w_rd_count)
    );

    assign in_ready     = w_in_ready;
    assign net_spike_in = r_net_spike_in;
    assign net_rst      = rst | (r_state == ST_CLEAR);
    assign out_valid    = (r_state == ST_RESULT);
    assign out_winner   = r_winner;
    assign out_count    = r_best;
    assign out_silent   = (r_state == ST_RESULT) && (r_best == '0);
    assign busy         = (r_state != ST_IDLE);

endmodule

// File: tb/tb_if_network_controller.sv
module tb_if_network_controller;

    localparam int NI = 4;
    localparam int NO = 3;
    localparam int NT = 4;
    localparam int CC = 2;
    localparam int DC = 2;
    localparam int CW = 3;          // clog2(NT+DC+1)
    localparam int IW = 2;          // clog2(NO)
    localparam int CNT_MAX = 7;     // 2^CW-1

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [NI-1:0] in_spikes;
    logic [NI-1:0] net_spike_in;
    logic          net_rst;
    logic [NO-1:0] net_spike_out;
    logic          out_valid;
    logic          out_ready;
    logic [IW-1:0] out_winner;
    logic [CW-1:0] out_count;
    logic          out_silent;
    logic          busy;

    int n_err = 0;
    int n_chk = 0;
    int cur   = 0;

    if_network_controller #(
        .NUM_INPUTS    (NI),
        .NUM_OUTPUTS   (NO),
        .NUM_TIMESTEPS (NT),
        .CLEAR_CYCLES  (CC),
        .DRAIN_CYCLES  (DC)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_spikes     (in_spikes),
        .net_spike_in  (net_spike_in),
        .net_rst       (net_rst),
        .net_spike_out (net_spike_out),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_winner    (out_winner),
        .out_count     (out_count),
        .out_silent    (out_silent),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    // One sample: in_valid per RUN cycle (LSB first), the beats, the network
    // output per RUN cycle and per DRAIN cycle, result backpressure, and the
    // expected result (or use_model to derive it from the counting rules).
    typedef struct {
        logic [23:0]         vp;
        logic [3:0][NI-1:0]  beats;
        logic [23:0][NO-1:0] run_out;
        logic [1:0][NO-1:0]  drain_out;
        int                  ready_delay;
        bit                  use_model;
        logic [IW-1:0]       exp_winner;
        logic [CW-1:0]       exp_count;
        logic                exp_silent;
    } sample_t;

    sample_t tbl[7];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s sample=%0d: got %0h want %0h", nm, cur, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    function automatic sample_t blank();
        sample_t s;
        s.vp          = '1;
        s.beats       = 16'h8421;
        s.run_out     = '0;
        s.drain_out   = '0;
        s.ready_delay = 0;
        s.use_model   = 1'b0;
        s.exp_winner  = '0;
        s.exp_count   = '0;
        s.exp_silent  = 1'b0;
        return s;
    endfunction

    task automatic do_sample(input sample_t s);
        int            hs;
        int            r;
        int            cnt[NO];
        int            best;
        int            win;
        logic          acc;
        logic [NI-1:0] prev;
        logic [IW-1:0] ew;
        logic [CW-1:0] ec;
        logic          es;
        hs   = 0;
        r    = 0;
        prev = '0;
        for (int k = 0; k < NO; k++) cnt[k] = 0;

        // IDLE: beat offered but not taken; spikes here must not count
        in_valid      = 1'b1;
        in_spikes     = s.beats[0];
        out_ready     = 1'b1;
        net_spike_out = '1;
        @(negedge clk);
        chk("idle_busy", busy, 0);
        chk("idle_in_ready", in_ready, 0);
        chk("idle_net_rst", net_rst, 0);
        chk("idle_out_valid", out_valid, 0);
        next_cycle();

        for (int c = 0; c < CC; c++) begin
            @(negedge clk);
            chk("clear_net_rst", net_rst, 1);
            chk("clear_in_ready", in_ready, 0);
            chk("clear_spike_in", net_spike_in, 0);
            chk("clear_busy", busy, 1);
            next_cycle();
        end

        while (hs < NT && r < 24) begin
            acc           = s.vp[r];
            in_valid      = acc;
            in_spikes     = acc ? s.beats[hs] : NI'($urandom);
            net_spike_out = s.run_out[r];
            for (int k = 0; k < NO; k++)
                if (net_spike_out[k] && cnt[k] < CNT_MAX) cnt[k]++;
            @(negedge clk);
            chk("run_in_ready", in_ready, 1);
            chk("run_net_rst", net_rst, 0);
            chk("run_spike_in", net_spike_in, prev);
            prev = acc ? s.beats[hs] : '0;
            if (acc) hs++;
            r++;
            next_cycle();
        end

        for (int d = 0; d < DC; d++) begin
            in_valid      = 1'b1;
            in_spikes     = NI'($urandom);
            net_spike_out = s.drain_out[d];
            for (int k = 0; k < NO; k++)
                if (net_spike_out[k] && cnt[k] < CNT_MAX) cnt[k]++;
            @(negedge clk);
            chk("drain_in_ready", in_ready, 0);
            chk("drain_spike_in", net_spike_in, prev);
            chk("drain_busy", busy, 1);
            prev = '0;
            next_cycle();
        end

        for (int c = 0; c < NO; c++) begin
            net_spike_out = '1;
            @(negedge clk);
            chk("scan_out_valid", out_valid, 0);
            chk("scan_in_ready", in_ready, 0);
            chk("scan_spike_in", net_spike_in, 0);
            next_cycle();
        end
        net_spike_out = '0;

        if (s.use_model) begin
            best = 0;
            win  = 0;
            for (int k = 0; k < NO; k++)
                if (cnt[k] > best) begin
                    best = cnt[k];
                    win  = k;
                end
            ew = IW'(win);
            ec = CW'(best);
            es = (best == 0);
        end else begin
            ew = s.exp_winner;
            ec = s.exp_count;
            es = s.exp_silent;
        end

        for (int w = 0; w <= s.ready_delay; w++) begin
            out_ready = (w == s.ready_delay);
            @(negedge clk);
            chk("res_out_valid", out_valid, 1);
            chk("res_winner", out_winner, ew);
            chk("res_count", out_count, ec);
            chk("res_silent", out_silent, es);
            chk("res_in_ready", in_ready, 0);
            next_cycle();
        end
        $display("sample %0d: beats=%0d run_cycles=%0d winner=%0d count=%0d silent=%0d",
                 cur, hs, r, ew, ec, es);
    endtask

    initial begin
        sample_t s;

        // Directed table
        tbl[0] = blank();                         // basic flow
        tbl[0].run_out[0] = 3'b001;
        tbl[0].run_out[1] = 3'b100;
        tbl[0].run_out[2] = 3'b100;
        tbl[0].run_out[3] = 3'b100;
        tbl[0].exp_winner = 2; tbl[0].exp_count = 3;

        tbl[1] = blank();                         // upstream stall 1,0,0,1,1,0,1
        tbl[1].vp = 24'hFFFF59;
        tbl[1].beats = 16'hC35A;
        tbl[1].run_out[1] = 3'b010;
        tbl[1].run_out[2] = 3'b010;
        tbl[1].run_out[6] = 3'b001;
        tbl[1].exp_winner = 1; tbl[1].exp_count = 2;

        tbl[2] = blank();                         // tie between 0 and 1
        tbl[2].run_out[0] = 3'b011;
        tbl[2].run_out[2] = 3'b011;
        tbl[2].exp_winner = 0; tbl[2].exp_count = 2;

        tbl[3] = blank();                         // silence
        tbl[3].exp_silent = 1'b1;

        tbl[4] = blank();                         // result backpressure
        tbl[4].ready_delay = 5;
        tbl[4].run_out[0] = 3'b101;
        tbl[4].run_out[3] = 3'b001;
        tbl[4].exp_winner = 0; tbl[4].exp_count = 2;

        tbl[5] = blank();                         // spike only in 2nd DRAIN cycle
        tbl[5].drain_out[1] = 3'b010;
        tbl[5].exp_winner = 1; tbl[5].exp_count = 1;

        tbl[6] = blank();                         // long stall: saturation
        tbl[6].vp = 24'hFF0701;
        tbl[6].run_out = {24{3'b100}};
        tbl[6].run_out[0] = 3'b101;
        tbl[6].drain_out = {2{3'b100}};
        tbl[6].exp_winner = 2; tbl[6].exp_count = 7;

        rst = 1'b1; in_valid = 1'b0; in_spikes = '0; net_spike_out = '0; out_ready = 1'b0;
        next_cycle();
        next_cycle();
        @(negedge clk);
        chk("rst_net_rst", net_rst, 1);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_winner", out_winner, 0);
        chk("rst_count", out_count, 0);
        chk("rst_silent", out_silent, 0);
        chk("rst_spike_in", net_spike_in, 0);
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        chk("idle_hold_busy", busy, 0);
        chk("idle_hold_net_rst", net_rst, 0);
        next_cycle();

        for (int i = 0; i < 7; i++) begin
            cur = i;
            do_sample(tbl[i]);
        end

        // Mid-run reset after two beats, then a clean sample
        cur = 100;
        in_valid = 1'b1; in_spikes = 4'h1; out_ready = 1'b1; net_spike_out = '0;
        next_cycle();
        next_cycle();
        next_cycle();
        net_spike_out = 3'b101;
        next_cycle();
        next_cycle();
        rst = 1'b1; in_valid = 1'b0;
        @(negedge clk);
        chk("midrst_net_rst", net_rst, 1);
        next_cycle();
        rst = 1'b0; net_spike_out = '0;
        @(negedge clk);
        chk("midrst_busy", busy, 0);
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_in_ready", in_ready, 0);
        chk("midrst_net_rst", net_rst, 0);
        chk("midrst_spike_in", net_spike_in, 0);
        next_cycle();
        cur = 101;
        do_sample(tbl[0]);

        // Randomised samples checked against the counting model
        for (int i = 0; i < 8; i++) begin
            cur = 200 + i;
            s = blank();
            s.vp = 24'($urandom) | 24'hF00000;
            s.beats = 16'($urandom);
            for (int j = 0; j < 24; j++)
                s.run_out[j] = (i % 2 == 0) ? (3'($urandom) & 3'($urandom))
                                            : (3'($urandom) & 3'($urandom) & 3'($urandom));
            s.drain_out[0] = 3'($urandom) & 3'($urandom);
            s.drain_out[1] = 3'($urandom) & 3'($urandom);
            s.ready_delay = $urandom_range(3, 0);
            s.use_model = 1'b1;
            do_sample(s);
        end

        in_valid = 1'b0;
        @(negedge clk);
        chk("final_idle_busy", busy, 0);
        chk("final_idle_out_valid", out_valid, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
